mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-ported word memory.
// Each access is sequenced IDLE -> ACCESS -> RESP, with round-robin arbitration on conflicts.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  if_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Request latched on entry to ACCESS; drives the memory bus until the next grant.
  typedef struct packed {
    logic              gnt_d;
    logic              we;
    logic              mis;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t            state, nxt;
  acc_t              acc;
  logic              last_d;
  logic              pick_d;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;

  // last_d=1 means data won the previous grant, so fetch wins the next conflict.
  always_comb begin
    pick_d   = d_req && (!if_req || !last_d);
    grant    = (state == IDLE) && (if_req || d_req);
    sel_addr = pick_d ? d_addr : if_addr;
    nxt      = state;
    case (state)
      IDLE:    if (if_req || d_req) nxt = ACCESS;
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      last_d    <= 1'b1;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_grants <= '0;
      d_grants  <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        acc.gnt_d <= pick_d;
        acc.we    <= pick_d && d_we;
        acc.mis   <= (sel_addr[1:0] != 2'b00);
        acc.addr  <= sel_addr;
        if (pick_d) acc.wdata <= d_wdata;
        last_d    <= pick_d;
      end
      if (state == ACCESS) begin
        if (acc.gnt_d) d_rdata  <= acc.mis ? '0 : mem_rdata;
        else           if_rdata <= acc.mis ? '0 : mem_rdata;
      end
      if (state == RESP) begin
        if (acc.gnt_d) begin
          if (d_grants != '1) d_grants <= d_grants + CNT_W'(1);
        end else begin
          if (if_grants != '1) if_grants <= if_grants + CNT_W'(1);
        end
      end
    end
  end

  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;
  assign mem_we    = (state == ACCESS) && acc.we && !acc.mis;
  assign if_valid  = (state == RESP) && !acc.gnt_d;
  assign d_valid   = (state == RESP) && acc.gnt_d;
  assign err       = (state == RESP) && acc.mis;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions, checked against a
// transaction-level model (reference memory, round-robin winner, saturating counts).
module tb_mem_arbiter;
  localparam int CNT_W = 2;

  logic        clk = 0, reset = 1;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, d_valid, err, mem_we;
  logic [CNT_W-1:0] if_grants, d_grants;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .if_grants(if_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return (i == 2) ? 32'h0050_0093 : 32'h1000_0000 + i * 32'h0101_0101;
  endfunction

  // Environment memory: reloads its seed image while reset is high.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) mem[i] <= seed(i);
    else if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
  end

  // Reference model state
  logic [31:0] refmem [16];
  bit          last_d;
  int          if_cnt, d_cnt;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  int          compared = 0, mismatched = 0;
  int          cmax = (1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) refmem[i] = seed(i);
    last_d = 1; if_cnt = 0; d_cnt = 0; exp_if_rdata = 0; exp_d_rdata = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_if_grants"}, if_grants, 0);
    chk({tag, "_d_grants"}, d_grants, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; if_req = 0; d_req = 0;
    #1 check_reset_outputs("rst");
    @(negedge clk); @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  // One transaction group: optional fetch and/or data request raised together, held until served.
  task automatic txn(input bit fi, input logic [31:0] fa,
                     input bit fd, input bit we, input logic [31:0] da, input logic [31:0] wd);
    bit          order [2];
    int          n, p;
    logic [31:0] a, exp_rd;
    bit          mis, exp_we;
    n = int'(fi) + int'(fd);
    order[0] = (fi && fd) ? !last_d : fd;
    order[1] = !order[0];
    @(negedge clk);
    if_req = fi; if_addr = fa; d_req = fd; d_we = we; d_addr = da; d_wdata = wd;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      bit ev_if, ev_d;
      @(negedge clk);
      ev_if = 0; ev_d = 0; exp_we = 0;
      for (int k = 0; k < n; k++) begin
        p = order[k];
        a = p ? da : fa;
        mis = (a[1:0] != 2'b00);
        if (cyc == 1 + 3 * k) begin
          chk("mem_addr", mem_addr, a);
          exp_we = p && we && !mis;
        end
        if (cyc == 2 + 3 * k) begin
          if (p) ev_d = 1; else ev_if = 1;
          exp_rd = mis ? 32'h0 : refmem[a[5:2]];
          if (p && we && !mis) refmem[a[5:2]] = wd;
          chk("err", err, mis);
          if (p) begin
            exp_d_rdata = exp_rd;
            chk("d_rdata", d_rdata, exp_rd);
            d_cnt = (d_cnt < cmax) ? d_cnt + 1 : d_cnt;
            d_req = 0;
          end else begin
            exp_if_rdata = exp_rd;
            chk("if_rdata", if_rdata, exp_rd);
            if_cnt = (if_cnt < cmax) ? if_cnt + 1 : if_cnt;
            if_req = 0;
          end
          last_d = p;
        end
      end
      chk("if_valid", if_valid, ev_if);
      chk("d_valid", d_valid, ev_d);
      chk("mem_we", mem_we, exp_we);
    end
    chk("if_grants", if_grants, if_cnt);
    chk("d_grants", d_grants, d_cnt);
    chk("if_rdata_hold", if_rdata, exp_if_rdata);
    chk("d_rdata_hold", d_rdata, exp_d_rdata);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single fetch from 0x8
    txn(1, 32'h8, 0, 0, 0, 0);
    chk("fetch_data_const", if_rdata, 32'h0050_0093);
    chk("fetch_cnt_const", if_grants, 1);

    // Store then load at 0xC
    txn(0, 0, 1, 1, 32'hC, 32'hDEAD_BEEF);
    txn(0, 0, 1, 0, 32'hC, 0);
    chk("load_const", d_rdata, 32'hDEAD_BEEF);

    // Conflicts from reset: fetch, data, fetch, data
    do_reset();
    txn(1, 32'h4, 1, 0, 32'h10, 0);
    txn(1, 32'h8, 1, 0, 32'h14, 0);
    chk("conflict_if_cnt", if_grants, 2);
    chk("conflict_d_cnt", d_grants, 2);

    // Misaligned store
    txn(0, 0, 1, 1, 32'h6, 32'h1234_5678);
    chk("mis_rdata", d_rdata, 0);

    // Reset during ACCESS of an aligned store
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h18; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("pre_rst_mem_we", mem_we, 1);
    reset = 1;
    #1 check_reset_outputs("mid_rst");
    d_req = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    model_reset();
    txn(1, 32'h20, 1, 0, 32'h18, 0);
    chk("post_rst_load", d_rdata, seed(6));

    // Fetch counter saturation at CNT_W=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      txn(1, 32'(4 * i), 0, 0, 0, 0);
      chk("sat_cnt", if_grants, (i < 3) ? i + 1 : 3);
    end

    // Random mix
    for (int i = 0; i < 40; i++) begin
      bit fi, fd, we;
      logic [31:0] fa, da;
      fi = $urandom_range(0, 1); fd = $urandom_range(0, 1); we = $urandom_range(0, 1);
      fa = $urandom_range(0, 63); da = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) fa[1:0] = 0;
      if ($urandom_range(0, 3) != 0) da[1:0] = 0;
      if (!fi && !fd) fd = 1;
      txn(fi, fa, fd, we, da, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
